pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Instruction-fetch stage downstream of the next-PC select mux. Holds the architectural fetch PC and issues in-order requests to instruction memory over a valid/ready handshake.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode. Exports pc+4 back to the next-PC mux.
- On a redirect (taken branch or jump), loads the supplied npc, flushes buffered instructions and discards stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- DEPTH, 2, FIFO entries; also the maximum of (in-flight requests + buffered entries). Legal values: 2..8.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- npc  in  32  target PC from next-PC mux; sampled only when redirect=1.
- redirect  in  1  load npc into fetch PC and flush.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  32  fetch address (word aligned).
- imem_req_ready  in  1  memory accepts request.
- imem_rsp_valid  in  1  response data valid; responses return in order, one per accepted request, at least 1 cycle after acceptance.
- imem_rsp_data  in  32  instruction word.
- id_valid  out  1  FIFO head valid to decode.
- id_pc  out  32  PC of head instruction.
- id_pc_add4  out  32  id_pc + 4, fed to the next-PC mux.
- id_inst  out  32  head instruction.
- id_ready  in  1  decode consumes head when id_valid & id_ready.

Behaviour:
- Reset (async, immediate):
  - fetch_pc=RESET_PC, inflight=0, discard=0, FIFO empty, state=BOOT.
  - imem_req_valid=0, imem_req_addr=RESET_PC.
  - id_valid=0, id_pc=0, id_pc_add4=4, id_inst=32'h0000_0013 (NOP).
  - Reset asserted mid-operation drops everything; responses arriving while rst=1 are ignored.
- FSM states BOOT, FETCH, FLUSH:
  - BOOT -> FETCH unconditionally on the first clock edge after rst deasserts.
  - FETCH -> FLUSH on redirect when the post-cycle in-flight count is nonzero; otherwise FETCH -> FETCH.
  - FLUSH -> FETCH when discard reaches 0 in that cycle.
  - Redirect while in FLUSH reloads fetch_pc and sets discard to the current in-flight count.
- Request issue:
  - imem_req_valid=1 only in FETCH, when redirect=0 and inflight + fifo_count < DEPTH.
  - imem_req_addr=fetch_pc. Request and address are held stable until accepted.
  - On accept: fetch_pc += 4 (wraps modulo 2^32), inflight += 1.
- Response:
  - Each imem_rsp_valid decrements inflight.
  - If discard != 0, the response is dropped and discard decrements.
  - Otherwise {pc, inst} is pushed into the FIFO. The pc comes from an internal issued-PC queue of DEPTH entries, in order.
  - A response is visible on id_* the cycle after it arrives (1-cycle latency).
- Dequeue: id_valid = FIFO not empty. A pop on id_valid & id_ready is allowed in the same cycle as a push.
- Outputs when the FIFO is empty: id_pc=0, id_pc_add4=4, id_inst=NOP.
- Redirect (any state):
  - fetch_pc <= {npc[31:2], 2'b00}.
  - FIFO and issued-PC queue are cleared; any same-cycle push and pop are cancelled.
  - discard <= inflight after this cycle's accept/response accounting.
  - A same-cycle response is treated as stale and dropped.
  - imem_req_valid is forced 0 in the redirect cycle.
- Invariant: inflight + fifo_count <= DEPTH. A response arriving with inflight=0 is a protocol error: ignored, with a simulation assertion.
- Width rules: all PC arithmetic is 32-bit unsigned. Counters are $clog2(DEPTH+1) bits.

Decomposition:
- Shared package/include:
  - RESET_PC default, NOP_INST = 32'h0000_0013.
  - FSM encodings: BOOT=2'd0, FETCH=2'd1, FLUSH=2'd2.
- One sub-module, fetch_fifo: parameterised width/depth synchronous FIFO with push, pop, flush, count, head.
  - Instantiated twice: issued-PC queue (32b) and instruction buffer (64b {pc,inst}).

Test Plan:
- Reset then memory always ready with 1-cycle response latency:
  - imem_req_addr sequence 0x0, 0x4, 0x8.
  - id_valid first rises 3 cycles after rst deasserts, with id_pc=0x0 and id_pc_add4=0x4.
- id_ready=0 held with DEPTH=2: after 2 accepted requests, imem_req_valid stays 0. FIFO holds PCs 0x0 and 0x4. Raising id_ready drains them in order.
- redirect=1 with npc=0x0000_0103 and 2 requests in flight:
  - Next imem_req_addr is 0x100, issued only after 2 stale responses are dropped.
  - The first id_pc afterwards is 0x100.
- Redirect in the same cycle as a response and a pop: FIFO ends empty, the response is discarded, and id_valid=0 next cycle.
- fetch_pc=0xFFFF_FFFC accepted: next imem_req_addr=0x0000_0000, and id_pc_add4 for that instruction is 0x0.
- rst asserted while 1 request is in flight: outputs return to reset values immediately, and the late response after reset release is ignored.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants, FSM encoding and the buffered-instruction record for the fetch unit.
package pc_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Fetch addresses are always word aligned; the low two bits of a target are ignored.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/response and decode-side handshake of the fetch unit.
interface pc_fetch_unit_if;

    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc_add4;
    logic [31:0] id_inst;
    logic        id_ready;

    // Fetch unit side.
    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output id_valid, id_pc, id_pc_add4, id_inst,
        input  id_ready
    );

    // Memory / decode side.
    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  id_valid, id_pc, id_pc_add4, id_inst,
        output id_ready
    );

endinterface

// File: rtl/pc_fetch_unit_fetch_fifo.sv
// Small synchronous FIFO with flush; head is the oldest entry, valid while count != 0.
// Flush wins over a same-cycle push or pop. Push while full is accepted only with a pop.
module fetch_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]               count_q, count_d;
    logic                        do_push, do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues in-order imem requests, buffers
// returned words with their PCs for decode, and squashes stale work on redirect.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2   // 2..8: buffer entries and in-flight + buffered cap
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc,
    input  logic        redirect,
    pc_fetch_unit_if.master bus
);

    localparam int            CW        = $clog2(DEPTH + 1);
    localparam logic [CW:0]   DEPTH_OCC = (CW + 1)'(DEPTH);

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] discard_q, discard_d;

    logic [CW-1:0] ibuf_count, pcq_count;
    logic [31:0]   pcq_head;
    fetch_entry_t  ibuf_head, ibuf_din;
    logic [CW:0]   occupancy;
    logic          req_valid, accept, rsp_take, rsp_keep, id_fire, id_valid;

    // Occupancy counts requests not yet returned plus words waiting for decode,
    // so every accepted request is guaranteed a buffer slot when it returns.
    assign occupancy = {1'b0, inflight_q} + {1'b0, ibuf_count};
    assign req_valid = (state_q == FETCH) && !redirect && (occupancy < DEPTH_OCC);
    assign accept    = req_valid && bus.imem_req_ready;
    // A response with nothing outstanding (e.g. a straggler from before reset) is ignored.
    assign rsp_take  = bus.imem_rsp_valid && (inflight_q != '0);
    assign rsp_keep  = rsp_take && (discard_q == '0) && !redirect;
    assign id_valid  = (ibuf_count != '0);
    assign id_fire   = id_valid && bus.id_ready && !redirect;

    // Next fetch PC, outstanding/discard accounting and FSM transition.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = word_align(npc);
        end else if (accept) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        inflight_d = inflight_q + CW'(accept) - CW'(rsp_take);

        discard_d = discard_q;
        if (redirect) begin
            // Everything still outstanding after this cycle belongs to the old path.
            discard_d = inflight_d;
        end else if (rsp_take && (discard_q != '0)) begin
            discard_d = discard_q - 1'b1;
        end

        state_d = state_q;
        unique case (state_q)
            BOOT:         state_d = FETCH;
            FETCH, FLUSH: state_d = (discard_d != '0) ? FLUSH : FETCH;
            default:      state_d = BOOT;
        endcase
    end

    // FSM and control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    // PCs of requests still expected back on the current path, oldest first.
    fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pc_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (rsp_keep),
        .flush (redirect),
        .din   (fetch_pc_q),
        .head  (pcq_head),
        .count (pcq_count)
    );

    assign ibuf_din = '{pc: pcq_head, inst: bus.imem_rsp_data};

    // Returned instructions paired with their PCs, waiting for decode.
    fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_inst_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (rsp_keep),
        .pop   (id_fire),
        .flush (redirect),
        .din   (ibuf_din),
        .head  (ibuf_head),
        .count (ibuf_count)
    );

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.id_valid       = id_valid;
    assign bus.id_pc          = id_valid ? ibuf_head.pc : 32'd0;
    assign bus.id_pc_add4     = id_valid ? (ibuf_head.pc + 32'd4) : 32'd4;
    assign bus.id_inst        = id_valid ? ibuf_head.inst : NOP_INST;

    // A response with nothing outstanding is a protocol error, except in the boot cycle
    // where a response issued before reset may still land.
    a_rsp_has_req : assert property (@(posedge clk) disable iff (rst)
        !(bus.imem_rsp_valid && (inflight_q == '0) && (state_q != BOOT)))
        else $error("pc_fetch_unit: imem response with no request outstanding");

    // Live PC-queue entries are exactly the outstanding requests not marked for discard.
    a_pcq_consistent : assert property (@(posedge clk) disable iff (rst)
        pcq_count == (inflight_q - discard_q))
        else $error("pc_fetch_unit: issued-PC queue out of step with in-flight count");

    a_occupancy : assert property (@(posedge clk) disable iff (rst)
        occupancy <= DEPTH_OCC)
        else $error("pc_fetch_unit: in-flight plus buffered exceeds DEPTH");

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: an epoch-tagged behavioural model predicts every
// output each cycle, and literal expectations pin the headline scenarios.
module tb_pc_fetch_unit;
    import pc_fetch_unit_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] npc = 32'd0;
    logic        redirect = 1'b0;

    pc_fetch_unit_if bus();

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .npc      (npc),
        .redirect (redirect),
        .bus      (bus.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Model: each request carries the redirect epoch it was issued in; a response is kept
    // only if its epoch is current and no redirect happens in the cycle it lands.
    typedef struct {int epoch; logic [31:0] pc;} out_t;
    typedef struct {logic [31:0] addr; int due;} mreq_t;

    out_t         m_out[$];
    fetch_entry_t m_buf[$];
    logic [31:0]  m_pc;
    int           m_epoch;
    bit           m_booted;

    mreq_t        memq[$];
    int           cyc = 0;
    int           lat = 1;
    bit           stray = 0;
    logic [31:0]  acc_log[$];
    int           rsp_cnt = 0;

    bit           obs_valid;
    logic [31:0]  obs_pc, obs_add4, obs_inst;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic model_reset();
        m_out.delete();
        m_buf.delete();
        memq.delete();
        m_pc     = 32'h0;
        m_epoch  = 0;
        m_booted = 0;
    endtask

    // One clock: drive memory response, compare against model, advance on the edge.
    task automatic cycle();
        bit          e_req, rsp_v, from_mem, acc_dut;
        int          stale;
        logic [31:0] rsp_d, acc_addr;
        out_t        o;
        if (rst) model_reset();
        rsp_v = 0; from_mem = 0; rsp_d = 32'h0;
        if (stray) begin
            rsp_v = 1; rsp_d = 32'hDEAD_BEEF;
        end else if (memq.size() > 0 && memq[0].due <= cyc) begin
            rsp_v = 1; from_mem = 1; rsp_d = mem_data(memq[0].addr);
        end
        bus.imem_rsp_valid = rsp_v;
        bus.imem_rsp_data  = rsp_d;
        #1;
        stale = 0;
        foreach (m_out[i]) if (m_out[i].epoch != m_epoch) stale++;
        e_req = m_booted && !rst && (stale == 0) && !redirect &&
                ((m_out.size() + m_buf.size()) < DEPTH);
        chk("req_valid", bus.imem_req_valid, 32'(e_req));
        chk("req_addr", bus.imem_req_addr, m_pc);
        if (m_buf.size() > 0) begin
            chk("id_valid", bus.id_valid, 32'd1);
            chk("id_pc", bus.id_pc, m_buf[0].pc);
            chk("id_pc_add4", bus.id_pc_add4, m_buf[0].pc + 32'd4);
            chk("id_inst", bus.id_inst, m_buf[0].inst);
        end else begin
            chk("id_valid", bus.id_valid, 32'd0);
            chk("id_pc", bus.id_pc, 32'd0);
            chk("id_pc_add4", bus.id_pc_add4, 32'd4);
            chk("id_inst", bus.id_inst, NOP_INST);
        end
        obs_valid = bus.id_valid;
        obs_pc    = bus.id_pc;
        obs_add4  = bus.id_pc_add4;
        obs_inst  = bus.id_inst;
        acc_dut   = bus.imem_req_valid && bus.imem_req_ready;
        acc_addr  = bus.imem_req_addr;
        @(posedge clk);
        if (!rst) begin
            if (from_mem) void'(memq.pop_front());
            if (rsp_v) rsp_cnt++;
            if (acc_dut) begin
                memq.push_back('{acc_addr, cyc + lat});
                acc_log.push_back(acc_addr);
            end
            if (!redirect && m_buf.size() > 0 && bus.id_ready) void'(m_buf.pop_front());
            if (rsp_v && m_out.size() > 0) begin
                o = m_out.pop_front();
                if (o.epoch == m_epoch && !redirect) m_buf.push_back('{pc: o.pc, inst: rsp_d});
            end
            if (e_req && bus.imem_req_ready) begin
                m_out.push_back('{m_epoch, m_pc});
                m_pc = m_pc + 32'd4;
            end
            if (redirect) begin
                m_epoch++;
                m_buf.delete();
                m_pc = {npc[31:2], 2'b00};
            end
            m_booted = 1;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; redirect = 0; stray = 0;
        bus.imem_req_ready = 1;
        cycle();
        cycle();
        rst = 0;
        acc_log.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, bus.imem_req_valid, 32'd0);
        chk({tag, "_req_addr"}, bus.imem_req_addr, 32'h0);
        chk({tag, "_id_valid"}, bus.id_valid, 32'd0);
        chk({tag, "_id_pc"}, bus.id_pc, 32'h0);
        chk({tag, "_id_pc_add4"}, bus.id_pc_add4, 32'h4);
        chk({tag, "_id_inst"}, bus.id_inst, 32'h0000_0013);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rise, n0, base, budget;
        bit seen;
        logic [31:0] seen_add4;
        bus.imem_req_ready = 1;
        bus.imem_rsp_valid = 0;
        bus.imem_rsp_data  = 0;
        bus.id_ready       = 1;
        model_reset();
        @(negedge clk);
        #1;
        chk_reset_outputs("reset");

        // Scenario 1: always-ready memory, 1-cycle latency; a stray response during reset.
        lat = 1;
        rst = 1;
        stray = 1; cycle(); stray = 0;
        cycle();
        rst = 0;
        acc_log.delete();
        rise = -1;
        for (int r = 0; r < 10; r++) begin
            cycle();
            if (obs_valid && rise < 0) begin
                rise = r;
                chk("first_id_pc", obs_pc, 32'h0);
                chk("first_id_pc_add4", obs_add4, 32'h4);
            end
        end
        chk("first_id_valid_cycle", 32'(rise), 32'd3);
        chk("acc_count_ge3", 32'(acc_log.size() >= 3), 32'd1);
        if (acc_log.size() >= 3) begin
            chk("addr_seq0", acc_log[0], 32'h0);
            chk("addr_seq1", acc_log[1], 32'h4);
            chk("addr_seq2", acc_log[2], 32'h8);
        end

        // Scenario 2: decode stalled; two requests fill the unit, then drain in order.
        bus.id_ready = 0;
        do_reset();
        for (int r = 0; r < 8; r++) cycle();
        chk("stall_acc_count", 32'(acc_log.size()), 32'd2);
        chk("stall_req_valid", bus.imem_req_valid, 32'd0);
        chk("stall_head_pc", bus.id_pc, 32'h0);
        bus.id_ready = 1;
        cycle();
        chk("drain_head_pc", bus.id_pc, 32'h4);
        cycle();
        for (int r = 0; r < 4; r++) cycle();

        // Scenario 3: redirect to unaligned 0x103 with two requests outstanding.
        lat = 3;
        do_reset();
        cycle(); cycle(); cycle();
        chk("pre_redir_inflight", 32'(acc_log.size()), 32'd2);
        n0 = acc_log.size();
        base = rsp_cnt;
        redirect = 1; npc = 32'h0000_0103;
        cycle();
        redirect = 0;
        budget = 0;
        while (acc_log.size() == n0 && budget < 20) begin cycle(); budget++; end
        chk("redir_accept_seen", 32'(acc_log.size() > n0), 32'd1);
        if (acc_log.size() > n0) chk("redir_addr", acc_log[n0], 32'h100);
        chk("redir_stale_drops", 32'(rsp_cnt - base), 32'd2);
        budget = 0;
        obs_valid = 0;
        while (!obs_valid && budget < 20) begin cycle(); budget++; end
        chk("redir_first_valid", 32'(obs_valid), 32'd1);
        chk("redir_first_pc", obs_pc, 32'h100);

        // Scenario 4: redirect coinciding with a response and a pop.
        lat = 1;
        do_reset();
        cycle(); cycle(); cycle();
        chk("coinc_pre_valid", bus.id_valid, 32'd1);
        redirect = 1; npc = 32'h0000_0040;
        cycle();
        redirect = 0;
        chk("coinc_post_valid", bus.id_valid, 32'd0);
        budget = 0;
        obs_valid = 0;
        while (!obs_valid && budget < 20) begin cycle(); budget++; end
        chk("coinc_first_pc", obs_pc, 32'h40);

        // Scenario 5: fetch PC wraps past 0xFFFF_FFFC.
        n0 = acc_log.size();
        redirect = 1; npc = 32'hFFFF_FFFC;
        cycle();
        redirect = 0;
        seen = 0; seen_add4 = 32'hX;
        budget = 0;
        while ((acc_log.size() < n0 + 2 || !seen) && budget < 30) begin
            cycle();
            if (obs_valid && obs_pc == 32'hFFFF_FFFC && !seen) begin
                seen = 1; seen_add4 = obs_add4;
            end
            budget++;
        end
        chk("wrap_acc_seen", 32'(acc_log.size() >= n0 + 2), 32'd1);
        if (acc_log.size() >= n0 + 2) begin
            chk("wrap_addr_a", acc_log[n0], 32'hFFFF_FFFC);
            chk("wrap_addr_b", acc_log[n0 + 1], 32'h0);
        end
        chk("wrap_head_seen", 32'(seen), 32'd1);
        chk("wrap_add4", seen_add4, 32'h0);

        // Scenario 6: reset with one request outstanding; its late response is ignored.
        lat = 3;
        do_reset();
        redirect = 1; npc = 32'h0000_0080;
        cycle();
        redirect = 0;
        cycle();
        chk("rst_mid_acc", 32'(acc_log.size()), 32'd1);
        bus.imem_req_ready = 0;
        cycle();
        rst = 1;
        #1;
        chk_reset_outputs("rst_mid");
        stray = 1; cycle(); stray = 0;
        cycle();
        rst = 0;
        stray = 1; cycle(); stray = 0;
        bus.imem_req_ready = 1;
        budget = 0;
        obs_valid = 0;
        while (!obs_valid && budget < 20) begin cycle(); budget++; end
        chk("rst_late_valid", 32'(obs_valid), 32'd1);
        chk("rst_late_pc", obs_pc, 32'h0);
        chk("rst_late_inst", obs_inst, 32'h1357_9BDF);
        for (int r = 0; r < 4; r++) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
